// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, read-modify-write for sub-doubleword stores.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of performing them.
module lsu_ctrl #(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ADDR_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [ADDR_W-1:0] resp_rdata,
   output logic [1:0]        resp_err,
   output logic [ADDR_W-1:0] mem_adrs,
   output logic [ADDR_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [ADDR_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t            state;
   logic              is_store;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] wdata;
   logic [1:0]        req_size;
   logic              illegal;
   logic              misaligned;
   logic              out_of_range;
   logic [1:0]        req_err;

   function automatic logic [ADDR_W-1:0] size_mask(input logic [1:0] size);
      case (size)
         2'd0:    return {{(ADDR_W-8){1'b0}}, 8'hFF};
         2'd1:    return {{(ADDR_W-16){1'b0}}, 16'hFFFF};
         2'd2:    return {{(ADDR_W-32){1'b0}}, 32'hFFFF_FFFF};
         default: return '1;
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] merge(input logic [ADDR_W-1:0] old_data,
                                              input logic [ADDR_W-1:0] new_data,
                                              input logic [1:0]        size);
      return (old_data & ~size_mask(size)) | (new_data & size_mask(size));
   endfunction

   function automatic logic [ADDR_W-1:0] extend(input logic [ADDR_W-1:0] data,
                                               input logic [2:0]        f3);
      logic sgn;
      case (f3[1:0])
         2'd0:    sgn = data[7];
         2'd1:    sgn = data[15];
         2'd2:    sgn = data[31];
         default: sgn = 1'b0;
      endcase
      sgn = sgn & ~f3[2];
      return (data & size_mask(f3[1:0])) | ({ADDR_W{sgn}} & ~size_mask(f3[1:0]));
   endfunction

   assign req_size = req_funct3[1:0];

   // Any access touches 8 bytes, so the range limit is the same for every size
   always_comb begin
      illegal      = req_is_store ? req_funct3[2] : (req_funct3 == 3'd7);
      misaligned   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      case (req_size)
         2'd1:    misaligned = req_addr[0];
         2'd2:    misaligned = |req_addr[1:0];
         2'd3:    misaligned = |req_addr[2:0];
         default: misaligned = 1'b0;
      endcase
`endif
      out_of_range = req_addr > ADDR_W'(MEM_BYTES - 8);
      if (illegal)           req_err = 2'b11;
      else if (misaligned)   req_err = 2'b01;
      else if (out_of_range) req_err = 2'b10;
      else                   req_err = 2'b00;
   end

   assign req_ready  = (state == IDLE) && !rst;
   assign resp_valid = (state == RESP);
   assign mem_read   = (state == READ) && !rst;
   assign mem_write  = (state == WRITE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         is_store   <= 1'b0;
         funct3     <= '0;
         wdata      <= '0;
         resp_rdata <= '0;
         resp_err   <= '0;
         mem_adrs   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  is_store <= req_is_store;
                  funct3   <= req_funct3;
                  wdata    <= req_wdata;
                  if (req_err != 2'b00) begin
                     resp_err   <= req_err;
                     resp_rdata <= '0;
                     state      <= RESP;
                  end else if (req_is_store && req_size == 2'd3) begin
                     mem_adrs  <= req_addr;
                     mem_wdata <= req_wdata;
                     state     <= WRITE;
                  end else begin
                     mem_adrs <= req_addr;
                     state    <= READ;
                  end
               end
            end
            // The read data feeds either the merged store word or the extended load result
            READ: begin
               if (is_store) begin
                  mem_wdata <= merge(mem_rdata, wdata, funct3[1:0]);
                  state     <= WRITE;
               end else begin
                  resp_rdata <= extend(mem_rdata, funct3);
                  resp_err   <= 2'b00;
                  state      <= RESP;
               end
            end
            WRITE: begin
               resp_rdata <= '0;
               resp_err   <= 2'b00;
               state      <= RESP;
            end
            RESP: begin
               resp_rdata <= '0;
               resp_err   <= 2'b00;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
